// File: rtl/mips_hazard_pkg.sv
// Shared types and field positions for the ID/EX hazard controller.
package mips_hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int unsigned MCTL_W       = 3;
    localparam int unsigned MCTL_MEMWRITE = 0;
    localparam int unsigned MCTL_MEMREAD = 1;
    localparam int unsigned MCTL_BRANCH  = 2;
    localparam int unsigned REG_W        = 5;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned PERF_W       = 16;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_sat_ctr.sv
// 16-bit saturating event counter with synchronous load and enable.
module hazard_sat_ctr
    import mips_hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [PERF_W-1:0] i_load_val,
    output logic [PERF_W-1:0] o_count
);

    logic [PERF_W-1:0] r_count;

    // Load wins over increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != {PERF_W{1'b1}})) begin
            r_count <= r_count + PERF_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/id_ex_hazard_ctl.sv
// Load-use stall and taken-branch flush control beside DECODE.
// Optional HAZARD_PERF_EN adds stall_cycles / flush_events counters.
module id_ex_hazard_ctl
    import mips_hazard_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MCTL_W-1:0] idex_m_ctl,
    input  logic [REG_W-1:0]  idex_rt,
    input  logic [REG_W-1:0]  ifid_rs,
    input  logic [REG_W-1:0]  ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic              busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
`endif
);

    if ((LOAD_STALL_CYCLES < 1) || (LOAD_STALL_CYCLES > 15)) begin : g_bad_stall
        $error("LOAD_STALL_CYCLES must be in 1..15");
    end
    if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 3)) begin : g_bad_flush
        $error("FLUSH_CYCLES must be in 1..3");
    end

    localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_hazard;
    logic             w_stall_drv;
    logic             w_flush_acc;
    logic             w_unused;

    assign w_hazard = idex_m_ctl[MCTL_MEMREAD] && (idex_rt != REG_ZERO) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    assign w_unused = ^{idex_m_ctl[MCTL_BRANCH], idex_m_ctl[MCTL_MEMWRITE],
                        w_stall_drv, w_flush_acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // Outputs are gated by rst_n so a branch pulse during reset stays invisible.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        busy        = 1'b0;
        w_stall_drv = 1'b0;
        w_flush_acc = 1'b0;

        if (rst_n) begin
            busy = (r_state != RUN);
            if (branch_taken) begin
                w_flush_acc = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    w_state_n = FLUSH;
                    w_cnt_n   = FLUSH_RELOAD;
                end else begin
                    w_state_n = RUN;
                    w_cnt_n   = '0;
                end
            end else begin
                case (r_state)
                    RUN: begin
                        if (w_hazard) begin
                            w_stall_drv = 1'b1;
                            if (LOAD_STALL_CYCLES > 1) begin
                                w_state_n = STALL;
                                w_cnt_n   = STALL_RELOAD;
                            end
                        end
                    end
                    STALL: begin
                        w_stall_drv = 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            w_state_n = RUN;
                            w_cnt_n   = '0;
                        end else begin
                            w_cnt_n = r_cnt - CNT_W'(1);
                        end
                    end
                    FLUSH: begin
                        w_flush_acc = 1'b0;
                        if (r_cnt == CNT_W'(1)) begin
                            w_state_n = RUN;
                            w_cnt_n   = '0;
                        end else begin
                            w_cnt_n = r_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_n = RUN;
                        w_cnt_n   = '0;
                    end
                endcase
            end

            if (w_stall_drv) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            if (branch_taken || (r_state == FLUSH)) begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    hazard_sat_ctr u_stall_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_stall_drv),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_count    (stall_cycles)
    );

    hazard_sat_ctr u_flush_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_flush_acc),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_count    (flush_events)
    );
`endif

endmodule

// File: doc/id_ex_hazard_ctl.md
Name: id_ex_hazard_ctl

Overview:
- Consumer of the ID/EX pipeline-register outputs, sitting beside the DECODE stage.
- Watches the instruction currently in EX (its M-control and rt field) against the instruction in IF/ID.
- Drives PC/IF-ID write enables and the ID/EX bubble select for load-use hazards.
- Drives the pipeline flushes for taken branches resolved in MEM, with a small FSM to stretch stalls for multi-cycle data memory.

Parameters:
- LOAD_STALL_CYCLES, 1, total stall cycles per load-use hazard (1..15).
- FLUSH_CYCLES, 1, cycles flush outputs stay asserted per taken branch (1..3).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- idex_m_ctl  in  3  ID/EX M-control {branch, memread, memwrite}; bit 1 = memread.
- idex_rt  in  5  ID/EX rt field (instr[20:16]).
- ifid_rs  in  5  IF/ID instr[25:21].
- ifid_rt  in  5  IF/ID instr[20:16].
- ifid_uses_rt  in  1  IF/ID instruction reads rt (R-type, store, beq).
- branch_taken  in  1  MEM-stage taken-branch pulse.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- idex_bubble  out  1  forces zero WB/M/EX control into ID/EX.
- flush_ifid  out  1  clear IF/ID.
- flush_idex  out  1  clear ID/EX.
- flush_exmem  out  1  clear EX/MEM control.
- busy  out  1  FSM not in RUN.

Behaviour:
- Reset (rst_n low, async): state=RUN, counter=0. Outputs while in reset: pc_write=1, ifid_write=1, idex_bubble=0, all flushes=0, busy=0.
- hazard (combinational) = idex_m_ctl[1] && idex_rt!=0 && (idex_rt==ifid_rs || (ifid_uses_rt && idex_rt==ifid_rt)).
- Stall outputs = pc_write=0, ifid_write=0, idex_bubble=1.
- Flush outputs = flush_ifid=flush_idex=flush_exmem=1, pc_write=1, ifid_write=1, idex_bubble=0.
- States:
  - RUN: outputs idle (pc_write=1, ifid_write=1, rest 0).
    - branch_taken: flush outputs this cycle (zero latency). If FLUSH_CYCLES>1 -> FLUSH, cnt=FLUSH_CYCLES-1.
    - else hazard: stall outputs this cycle. If LOAD_STALL_CYCLES>1 -> STALL, cnt=LOAD_STALL_CYCLES-1.
  - STALL: stall outputs, busy=1. cnt decrements each cycle; cnt==1 -> RUN next edge.
    - hazard is ignored here, since the bubble has cleared memread.
  - FLUSH: flush outputs, busy=1. cnt decrements each cycle; cnt==1 -> RUN.
- Priority: branch_taken over hazard in every state.
  - branch_taken in STALL aborts the stall: flush outputs that cycle, then FLUSH or RUN per FLUSH_CYCLES.
  - branch_taken in FLUSH restarts cnt=FLUSH_CYCLES-1.
- Register $0 never causes a hazard.
- A load followed by a store using the loaded rt still stalls (no MEM-MEM forwarding).
- Counter width is 4 bits; parameter values outside range are an elaboration error.
- Reset asserted mid-STALL or mid-FLUSH: immediate return to RUN with idle outputs.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- With it: adds outputs stall_cycles[15:0] and flush_events[15:0].
  - stall_cycles increments every cycle stall outputs are driven.
  - flush_events increments on each branch_taken accepted.
  - Both saturate at 16'hFFFF and reset to 0 on rst_n.
- Without it: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_hazard_pkg: state enum {RUN, STALL, FLUSH}; MCTL_MEMREAD=1, MCTL_MEMWRITE=0, MCTL_BRANCH=2; REG_ZERO=5'd0.
- One sub-module: hazard_sat_ctr (16-bit saturating counter with enable and async active-low reset), instantiated twice under HAZARD_PERF_EN.

Test Plan:
- Reset, hold rst_n=0 with branch_taken=1 -> pc_write=1, ifid_write=1, all flushes=0, busy=0.
- idex_m_ctl=3'b010, idex_rt=8, ifid_rs=8, LOAD_STALL_CYCLES=1 -> exactly one cycle of stall outputs; next cycle (bubble in ID/EX) idle.
- Same hazard with LOAD_STALL_CYCLES=3 -> three consecutive stall cycles, busy=1 for cycles 2-3, then RUN.
- idex_rt=0 with memread=1 and ifid_rs=0 -> no stall; idex_rt=9, ifid_rt=9, ifid_uses_rt=0 -> no stall.
- branch_taken and hazard in the same cycle -> flush outputs, no stall. branch_taken in cycle 2 of a 3-cycle stall -> flush that cycle, RUN after.
- HAZARD_PERF_EN, 4 single-cycle stalls plus 2 branches -> stall_cycles=4, flush_events=2. Preload near max -> counter holds at 16'hFFFF.
